tune_controller: RTL and testbench
==================================

# tune_controller

Sequencing controller for the tuning datapath. It drives `sys_status` and `tune_status` into the offset accumulator, and steps through the hour, minute and second fields on key presses. On completion it adds the accumulated offset to the captured base value (current time or alarm time), normalises the result modulo 86400 and emits a one-cycle load strobe to the matching counter. It sits between the key filter, the offset accumulator and the time/alarm counters.

## Interface
- `TIMEOUT_CYCLES`, default 32'd500_000_000: idle cycles with no key activity before tuning is abandoned (10 s at 50 MHz).
- `OFFSET_INIT`, default 20'h7ffff: zero point of the offset encoding.
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: asynchronous, active-high reset.
- `neg_keys_filtered` input 4: one-cycle filtered key pulses.
  - 4'b1000 = SET
  - 4'b0001 = ALARM/CANCEL
  - 4'b0010 = LEFT
  - 4'b0100 = RIGHT
- `offset` input 20: offset from the accumulator, biased by OFFSET_INIT.
- `cur_time` input 17: current time of day, in seconds (0..86399).
- `alarm_time` input 17: current alarm setting, in seconds (0..86399).
- `sys_status` output 3: system status.
  - 3'd0 = S_NORMAL
  - 3'd3 = S_TUNING
  - 3'd5 = S_ALARMTUNING
- `tune_status` output 2: field being tuned.
  - 3 = T_HOUR
  - 2 = T_MINUTE
  - 1 = T_SECOND
  - 0 = T_NONE
- `load_value` output 17: normalised result; valid while a strobe is high.
- `time_load` output 1: one-cycle strobe that loads `load_value` into the time counter.
- `alarm_load` output 1: one-cycle strobe that loads `load_value` into the alarm counter.

## Operation
- Key decoding:
  - Only the exact one-hot patterns above are commands.
  - Any nonzero key value restarts the timeout counter.
- FSM states are IDLE, TUNE, NORM and LOAD. A `target` flag records whether time or alarm is being tuned.
- IDLE:
  - Outputs: `sys_status`=0, `tune_status`=0.
  - SET selects target = time, `sys_status`=3, `tune_status`=T_HOUR, next state TUNE.
  - ALARM selects target = alarm, `sys_status`=5, `tune_status`=T_HOUR, next state TUNE.
- TUNE, on SET:
  - T_HOUR advances to T_MINUTE; T_MINUTE advances to T_SECOND.
  - At T_SECOND, SET commits. In that same cycle the block captures the accumulator `acc` = {base} + `offset` − OFFSET_INIT, where base is `cur_time` for time or `alarm_time` for alarm. `acc` is signed 22-bit.
  - After the commit it sets `tune_status`=T_NONE and goes to NORM.
- TUNE, other keys:
  - ALARM/CANCEL: back to IDLE, no strobe.
  - LEFT/RIGHT: no state change; they only restart the timeout.
- TUNE, timeout: when the timeout counter reaches TIMEOUT_CYCLES−1 with no key activity, the block cancels as for ALARM/CANCEL.
- NORM, one correction per cycle:
  - If `acc` < 0: `acc` += 86400.
  - Else if `acc` ≥ 86400: `acc` −= 86400.
  - Else: `load_value` ← `acc[16:0]`, next state LOAD.
  - Keys are ignored in NORM.
- LOAD:
  - Asserts `time_load` or `alarm_load` for exactly one cycle, according to target.
  - Next state is IDLE with `sys_status`=0.
  - `load_value` holds its value until the next commit.
- Arithmetic bounds:
  - `acc` ranges from −524287 to +610687.
  - At most 7 corrections are ever needed.
  - A 22-bit signed accumulator cannot overflow.
- `sys_status` stays at 3 or 5 through NORM and LOAD.

## Timing
- Reset values:
  - State IDLE, `sys_status`=0, `tune_status`=0.
  - `load_value`=0, `time_load`=0, `alarm_load`=0.
  - Timeout counter = 0.
- `sys_status` and `tune_status` change in the cycle after the key pulse. All outputs are registered.
- Commit latency: SET in T_SECOND at cycle N gives NORM at N+1. With k corrections (0..7), the strobe is high in cycle N+2+k and `sys_status` returns to 0 at N+3+k.
- `offset` and the base value are sampled only at cycle N. Changes in later cycles do not affect the result.
- Reset asserted in any state, including NORM or LOAD, returns all outputs to reset values immediately. No strobe is emitted.
- The timeout counter clears on entry to TUNE and on any key activity. It does not run outside TUNE.

## Test plan
- Reset mid-NORM (`acc` = −524287) → outputs 0 at once; no strobe after `rst` is released.
- Time tune, `cur_time`=3600, `offset`=0x7FFFF+3660, SET×4 → `tune_status` sequence 3,2,1,0; `time_load` pulse at N+2 with `load_value`=7260; `alarm_load` stays 0.
- `cur_time`=0, `offset`=0x7FFFE → k=1, `load_value`=86399, strobe at N+3.
- `cur_time`=86399, `offset`=0xFFFFF → 7 subtractions, `load_value`=5887, strobe at N+9; changing `cur_time` after N has no effect.
- ALARM from IDLE → `sys_status`=5; SET×3 with `alarm_time`=25200 and `offset`=0x7FFFF−60 → `alarm_load` with `load_value`=25140. Separately, ALARM pressed during TUNE → IDLE with no strobe.
- `TIMEOUT_CYCLES`=16:
  - 16 idle cycles in TUNE → IDLE, no strobe.
  - A LEFT at idle cycle 15 → remains in TUNE, and the counter restarts from 0.

Source files
------------

// File: rtl/tune_if.sv
`default_nettype none
// ============================================================================
// tune_if : key, offset and base-time inputs plus status and load outputs
//           of the tuning controller, grouped as one bus.
// Revision: 1.0
// ============================================================================

interface tune_if;
    logic [3:0]  neg_keys_filtered;
    logic [19:0] offset;
    logic [16:0] cur_time;
    logic [16:0] alarm_time;
    logic [2:0]  sys_status;
    logic [1:0]  tune_status;
    logic [16:0] load_value;
    logic        time_load;
    logic        alarm_load;

    modport master (
        input  neg_keys_filtered, offset, cur_time, alarm_time,
        output sys_status, tune_status, load_value, time_load, alarm_load
    );

    modport slave (
        output neg_keys_filtered, offset, cur_time, alarm_time,
        input  sys_status, tune_status, load_value, time_load, alarm_load
    );
endinterface

`default_nettype wire

// File: rtl/tune_controller.sv
`default_nettype none
// ============================================================================
// tune_controller : steps hour/minute/second tuning on key pulses, then adds
//                   the biased offset to the captured base, wraps it modulo
//                   86400 and strobes the time or alarm counter.
// Revision: 1.0
// ============================================================================

module tune_controller #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
    parameter logic [19:0] OFFSET_INIT    = 20'h7ffff
) (
    input  logic      clk,
    input  logic      rst,
    tune_if.master    bus
);

    localparam logic [3:0]         c_key_set      = 4'b1000;
    localparam logic [3:0]         c_key_alarm    = 4'b0001;
    localparam logic [2:0]         c_s_normal     = 3'd0;
    localparam logic [2:0]         c_s_tuning     = 3'd3;
    localparam logic [2:0]         c_s_alarmtune  = 3'd5;
    localparam logic [1:0]         c_t_hour       = 2'd3;
    localparam logic [1:0]         c_t_minute     = 2'd2;
    localparam logic [1:0]         c_t_second     = 2'd1;
    localparam logic [1:0]         c_t_none       = 2'd0;
    localparam logic signed [21:0] c_day          = 22'sd86400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TUNE = 2'd1,
        ST_NORM = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    state_t             r_state,      w_state;
    logic               r_target,     w_target;     // 1 = alarm, 0 = time
    logic [2:0]         r_sys,        w_sys;
    logic [1:0]         r_tune,       w_tune;
    logic signed [21:0] r_acc,        w_acc;
    logic [16:0]        r_load_value, w_load_value;
    logic               r_time_load,  w_time_load;
    logic               r_alarm_load, w_alarm_load;
    logic [31:0]        r_cnt,        w_cnt;

    logic [16:0]        w_base;
    logic signed [21:0] w_acc_commit;
    logic               w_key_any;

    assign w_key_any    = |bus.neg_keys_filtered;
    assign w_base       = r_target ? bus.alarm_time : bus.cur_time;
    assign w_acc_commit = $signed({5'd0, w_base}) + $signed({2'd0, bus.offset})
                        - $signed({2'd0, OFFSET_INIT});

    always_comb begin
        w_state      = r_state;
        w_target     = r_target;
        w_sys        = r_sys;
        w_tune       = r_tune;
        w_acc        = r_acc;
        w_load_value = r_load_value;
        w_time_load  = 1'b0;
        w_alarm_load = 1'b0;
        w_cnt        = 32'd0;

        case (r_state)
            ST_IDLE: begin
                w_sys  = c_s_normal;
                w_tune = c_t_none;
                if (bus.neg_keys_filtered == c_key_set) begin
                    w_target = 1'b0;
                    w_sys    = c_s_tuning;
                    w_tune   = c_t_hour;
                    w_state  = ST_TUNE;
                end else if (bus.neg_keys_filtered == c_key_alarm) begin
                    w_target = 1'b1;
                    w_sys    = c_s_alarmtune;
                    w_tune   = c_t_hour;
                    w_state  = ST_TUNE;
                end
            end

            ST_TUNE: begin
                if (w_key_any) begin
                    if (bus.neg_keys_filtered == c_key_set) begin
                        case (r_tune)
                            c_t_hour:   w_tune = c_t_minute;
                            c_t_minute: w_tune = c_t_second;
                            default: begin
                                w_acc   = w_acc_commit;
                                w_tune  = c_t_none;
                                w_state = ST_NORM;
                            end
                        endcase
                    end else if (bus.neg_keys_filtered == c_key_alarm) begin
                        w_sys   = c_s_normal;
                        w_tune  = c_t_none;
                        w_state = ST_IDLE;
                    end
                end else if (r_cnt == TIMEOUT_CYCLES - 32'd1) begin
                    w_sys   = c_s_normal;
                    w_tune  = c_t_none;
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end

            // One wrap per cycle keeps the adder single-stage.
            ST_NORM: begin
                if (r_acc[21]) begin
                    w_acc = r_acc + c_day;
                end else if (r_acc >= c_day) begin
                    w_acc = r_acc - c_day;
                end else begin
                    w_load_value = r_acc[16:0];
                    w_time_load  = ~r_target;
                    w_alarm_load = r_target;
                    w_state      = ST_LOAD;
                end
            end

            default: begin
                w_sys   = c_s_normal;
                w_tune  = c_t_none;
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_target     <= 1'b0;
            r_sys        <= c_s_normal;
            r_tune       <= c_t_none;
            r_acc        <= '0;
            r_load_value <= '0;
            r_time_load  <= 1'b0;
            r_alarm_load <= 1'b0;
            r_cnt        <= 32'd0;
        end else begin
            r_state      <= w_state;
            r_target     <= w_target;
            r_sys        <= w_sys;
            r_tune       <= w_tune;
            r_acc        <= w_acc;
            r_load_value <= w_load_value;
            r_time_load  <= w_time_load;
            r_alarm_load <= w_alarm_load;
            r_cnt        <= w_cnt;
        end
    end

    assign bus.sys_status  = r_sys;
    assign bus.tune_status = r_tune;
    assign bus.load_value  = r_load_value;
    assign bus.time_load   = r_time_load;
    assign bus.alarm_load  = r_alarm_load;

endmodule

`default_nettype wire

// File: tb/tb_tune_controller.sv
`default_nettype none
// ============================================================================
// tb_tune_controller : directed scenarios with hand-computed expectations.
// Revision: 1.0
// ============================================================================

module tb_tune_controller;

    localparam logic [3:0] c_set   = 4'b1000;
    localparam logic [3:0] c_alarm = 4'b0001;
    localparam logic [3:0] c_left  = 4'b0010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    tune_if bus ();

    tune_controller #(
        .TIMEOUT_CYCLES (32'd16),
        .OFFSET_INIT    (20'h7ffff)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Called at a negedge: key visible for one posedge, returns at next negedge.
    task automatic press(input logic [3:0] k);
        bus.neg_keys_filtered = k;
        @(negedge clk);
        bus.neg_keys_filtered = 4'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bus.sys_status, bus.tune_status} !== 5'd0) begin
            errors++; $display("FAIL reset_status got=%0d/%0d want=0/0", bus.sys_status, bus.tune_status);
        end
        vectors++;
        if ({bus.load_value, bus.time_load, bus.alarm_load} !== 19'd0) begin
            errors++; $display("FAIL reset_load got=%0d/%b/%b want=0/0/0", bus.load_value, bus.time_load, bus.alarm_load);
        end
        rst = 1'b0;
        @(negedge clk);
        press(4'b1001);
        vectors++;
        if (bus.sys_status !== 3'd0) begin
            errors++; $display("FAIL non_onehot_idle got=%0d want=0", bus.sys_status);
        end
    endtask

    task automatic test_time_tune();
        bus.cur_time = 17'd3600;
        bus.offset   = 20'h7ffff + 20'd3660;
        for (int i = 0; i < 4; i++) begin
            press(c_set);
            vectors++;
            if (bus.tune_status !== 2'(3 - i) || bus.sys_status !== 3'd3) begin
                errors++; $display("FAIL time_seq[%0d] got=%0d/%0d want=%0d/3", i, bus.tune_status, bus.sys_status, 3 - i);
            end
        end
        // Now in cycle N+1; k = 0 so strobe at N+2.
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (bus.time_load !== (c == 2) || bus.alarm_load !== 1'b0) begin
                errors++; $display("FAIL time_strobe c=N+%0d got=%b/%b want=%b/0", c, bus.time_load, bus.alarm_load, c == 2);
            end
            if (c == 2) begin
                vectors++;
                if (bus.load_value !== 17'd7260) begin
                    errors++; $display("FAIL time_value got=%0d want=7260", bus.load_value);
                end
            end
            if (c == 3) begin
                vectors++;
                if (bus.sys_status !== 3'd0 || bus.load_value !== 17'd7260) begin
                    errors++; $display("FAIL time_done got=%0d/%0d want=0/7260", bus.sys_status, bus.load_value);
                end
            end
            if (c < 3) @(negedge clk);
        end
    endtask

    task automatic test_wrap_negative();
        bus.cur_time = 17'd0;
        bus.offset   = 20'h7fffe;
        for (int i = 0; i < 4; i++) press(c_set);
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if (bus.time_load !== (c == 3)) begin
                errors++; $display("FAIL neg_strobe c=N+%0d got=%b want=%b", c, bus.time_load, c == 3);
            end
            if (c == 3) begin
                vectors++;
                if (bus.load_value !== 17'd86399) begin
                    errors++; $display("FAIL neg_value got=%0d want=86399", bus.load_value);
                end
            end
            if (c < 4) @(negedge clk);
        end
        vectors++;
        if (bus.sys_status !== 3'd0) begin
            errors++; $display("FAIL neg_done got=%0d want=0", bus.sys_status);
        end
    endtask

    task automatic test_wrap_max();
        bus.cur_time = 17'd86399;
        bus.offset   = 20'hfffff;
        for (int i = 0; i < 4; i++) press(c_set);
        // Inputs changed after the commit cycle must not matter.
        bus.cur_time = 17'd12345;
        bus.offset   = 20'd0;
        for (int c = 1; c <= 10; c++) begin
            vectors++;
            if (bus.time_load !== (c == 9) || bus.sys_status !== ((c == 10) ? 3'd0 : 3'd3)) begin
                errors++; $display("FAIL max_seq c=N+%0d got=%b/%0d want=%b/%0d", c, bus.time_load, bus.sys_status, c == 9, (c == 10) ? 0 : 3);
            end
            if (c == 9) begin
                vectors++;
                if (bus.load_value !== 17'd5887) begin
                    errors++; $display("FAIL max_value got=%0d want=5887", bus.load_value);
                end
            end
            if (c < 10) @(negedge clk);
        end
    endtask

    task automatic test_alarm_tune();
        bus.alarm_time = 17'd25200;
        bus.offset     = 20'h7ffff - 20'd60;
        press(c_alarm);
        vectors++;
        if (bus.sys_status !== 3'd5 || bus.tune_status !== 2'd3) begin
            errors++; $display("FAIL alarm_enter got=%0d/%0d want=5/3", bus.sys_status, bus.tune_status);
        end
        for (int i = 0; i < 3; i++) press(c_set);
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (bus.alarm_load !== (c == 2) || bus.time_load !== 1'b0) begin
                errors++; $display("FAIL alarm_strobe c=N+%0d got=%b/%b want=%b/0", c, bus.alarm_load, bus.time_load, c == 2);
            end
            if (c == 2) begin
                vectors++;
                if (bus.load_value !== 17'd25140 || bus.sys_status !== 3'd5) begin
                    errors++; $display("FAIL alarm_value got=%0d/%0d want=25140/5", bus.load_value, bus.sys_status);
                end
            end
            if (c < 3) @(negedge clk);
        end
    endtask

    task automatic test_cancel();
        int strobes = 0;
        press(c_alarm);
        press(c_set);
        press(c_alarm);
        vectors++;
        if (bus.sys_status !== 3'd0 || bus.tune_status !== 2'd0) begin
            errors++; $display("FAIL cancel_state got=%0d/%0d want=0/0", bus.sys_status, bus.tune_status);
        end
        for (int c = 0; c < 10; c++) begin
            if (bus.time_load || bus.alarm_load) strobes++;
            @(negedge clk);
        end
        vectors++;
        if (strobes !== 0) begin
            errors++; $display("FAIL cancel_strobe got=%0d want=0", strobes);
        end
    endtask

    task automatic test_timeout();
        int strobes = 0;
        press(c_set);
        for (int j = 1; j < 16; j++) @(negedge clk);
        vectors++;
        if (bus.sys_status !== 3'd3) begin
            errors++; $display("FAIL timeout_early got=%0d want=3", bus.sys_status);
        end
        @(negedge clk);
        vectors++;
        if (bus.sys_status !== 3'd0 || bus.tune_status !== 2'd0) begin
            errors++; $display("FAIL timeout_expire got=%0d/%0d want=0/0", bus.sys_status, bus.tune_status);
        end
        // LEFT in idle cycle 15 restarts the count: 16 more idle cycles needed.
        press(c_set);
        for (int j = 1; j < 15; j++) @(negedge clk);
        press(c_left);
        for (int j = 1; j < 16; j++) begin
            if (bus.time_load || bus.alarm_load) strobes++;
            @(negedge clk);
        end
        vectors++;
        if (bus.sys_status !== 3'd3 || bus.tune_status !== 2'd3) begin
            errors++; $display("FAIL timeout_restart got=%0d/%0d want=3/3", bus.sys_status, bus.tune_status);
        end
        @(negedge clk);
        vectors++;
        if (bus.sys_status !== 3'd0 || strobes !== 0) begin
            errors++; $display("FAIL timeout_after_left got=%0d/%0d want=0/0", bus.sys_status, strobes);
        end
    endtask

    task automatic test_reset_mid_norm();
        int strobes = 0;
        bus.cur_time = 17'd0;
        bus.offset   = 20'd0;
        for (int i = 0; i < 4; i++) press(c_set);
        @(negedge clk);
        vectors++;
        if (bus.sys_status !== 3'd3) begin
            errors++; $display("FAIL norm_before_rst got=%0d want=3", bus.sys_status);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.sys_status, bus.tune_status, bus.load_value, bus.time_load, bus.alarm_load} !== 24'd0) begin
            errors++; $display("FAIL rst_mid_norm got=%0d/%0d/%0d/%b/%b want=all 0", bus.sys_status, bus.tune_status, bus.load_value, bus.time_load, bus.alarm_load);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.time_load || bus.alarm_load || bus.sys_status != 3'd0) strobes++;
            @(negedge clk);
        end
        vectors++;
        if (strobes !== 0) begin
            errors++; $display("FAIL rst_no_strobe got=%0d want=0", strobes);
        end
    endtask

    initial begin
        bus.neg_keys_filtered = 4'd0;
        bus.offset            = 20'h7ffff;
        bus.cur_time          = 17'd0;
        bus.alarm_time        = 17'd0;
        test_reset();
        test_time_tune();
        test_wrap_negative();
        test_wrap_max();
        test_alarm_tune();
        test_cancel();
        test_timeout();
        test_reset_mid_norm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
